// File: rtl/vmem_seq_pkg.sv
// Shared types and helpers for the vector memory read sequencer.
package vmem_seq_pkg;

    // Sequencer FSM encoding
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } seq_state_e;

    // Tag travelling alongside each outstanding read
    typedef struct packed {
        logic vld;
        logic last;
    } rd_tag_t;

    // Width able to hold 0..depth (FIFO occupancy and credit values)
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/vmem_seq_fifo.sv
// Synchronous show-ahead FIFO with occupancy count; head reads zero when empty.
module vmem_seq_fifo
    import vmem_seq_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             push_i,
    input  logic [WIDTH-1:0]                 push_data_i,
    input  logic                             pop_i,
    output logic [WIDTH-1:0]                 head_o,
    output logic                             empty_o,
    output logic [credit_width(DEPTH)-1:0]   count_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = credit_width(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             pop_ok;

    // Upstream credit accounting guarantees a push never meets a full FIFO
    assign pop_ok  = pop_i && (count_q != '0);
    assign empty_o = (count_q == '0);
    assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Pointer and occupancy tracking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_ok) rd_ptr_q <= rd_ptr_q + PW'(1);
            case ({push_i, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage; contents are only observed through the gated head
    always_ff @(posedge clk) begin
        if (push_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/vector_memory_read_sequencer.sv
// Issues strided all-lane reads into a banked vector memory and streams the
// returned lane vectors out, using credits so every in-flight read fits the FIFO.
module vector_memory_read_sequencer
    import vmem_seq_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned ADDR_WIDTH   = 16,
    parameter int unsigned NUM_ELEM     = 64,
    parameter int unsigned READ_LATENCY = 1,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           cfg_start,
    input  logic [ADDR_WIDTH-1:0]          cfg_base_addr,
    input  logic [ADDR_WIDTH-1:0]          cfg_stride,
    input  logic [CNT_WIDTH-1:0]           cfg_num_iter,
    input  logic [NUM_ELEM-1:0]            cfg_lane_mask,
    output logic                           busy,
    output logic                           done,
    output logic [NUM_ELEM-1:0]            mem_read_req,
    output logic [ADDR_WIDTH*NUM_ELEM-1:0] mem_read_addr,
    input  logic [DATA_WIDTH*NUM_ELEM-1:0] mem_read_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [DATA_WIDTH*NUM_ELEM-1:0] out_data,
    output logic                           out_last
);

    localparam int unsigned VEC_W = DATA_WIDTH * NUM_ELEM;
    localparam int unsigned ENT_W = VEC_W + 1;
    localparam int unsigned CW    = credit_width(FIFO_DEPTH);

    seq_state_e            state_q, state_d;
    logic [ADDR_WIDTH-1:0] stride_q, stride_d;
    logic [NUM_ELEM-1:0]   mask_q, mask_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [CNT_WIDTH-1:0]  beats_q, beats_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [NUM_ELEM-1:0]   req_mask_q, req_mask_d;
    rd_tag_t               req_tag_q, req_tag_d;
    logic                  done_q, done_d;
    rd_tag_t               pipe_q [READ_LATENCY];

    logic                  accept;
    logic                  want_issue;
    logic                  issue;
    logic                  credit_ok;
    int unsigned           occ;
    logic [ADDR_WIDTH-1:0] src_addr;
    logic [ADDR_WIDTH-1:0] src_stride;
    logic [CNT_WIDTH-1:0]  src_beats;
    logic [NUM_ELEM-1:0]   src_mask;

    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic [CW-1:0]         fifo_count;
    logic [ENT_W-1:0]      fifo_head;
    logic [VEC_W-1:0]      masked_data;
    logic                  head_last;

    // A start is taken only in IDLE and never in the cycle done is high
    assign accept = (state_q == IDLE) && cfg_start && !done_q;

    // Beat source: fresh config on accept, otherwise the running burst state
    assign src_addr   = accept ? cfg_base_addr : next_addr_q;
    assign src_stride = accept ? cfg_stride    : stride_q;
    assign src_beats  = accept ? cfg_num_iter  : beats_q;
    assign src_mask   = accept ? cfg_lane_mask : mask_q;

    // Occupancy = buffered beats + reads on the bus + reads in the latency pipe
    always_comb begin
        occ = 32'(fifo_count) + 32'(req_tag_q.vld);
        for (int unsigned k = 0; k < READ_LATENCY; k++) begin
            occ = occ + 32'(pipe_q[k].vld);
        end
    end

    // A pop frees its credit only from the following cycle
    assign credit_ok  = (occ < FIFO_DEPTH);
    assign want_issue = accept ? (cfg_num_iter != '0)
                               : ((state_q == ISSUE) && (beats_q != '0));
    assign issue      = want_issue && credit_ok;

    assign fifo_pop  = out_valid && out_ready;
    assign head_last = fifo_head[VEC_W];

    // FSM state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept && (cfg_num_iter != '0)) state_d = ISSUE;
            ISSUE:   if (beats_q == '0) state_d = DRAIN;
            DRAIN:   if (fifo_pop && head_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output / datapath next values
    always_comb begin
        stride_d    = stride_q;
        mask_d      = mask_q;
        next_addr_d = next_addr_q;
        beats_d     = beats_q;
        addr_d      = addr_q;
        req_mask_d  = '0;
        req_tag_d   = '0;
        done_d      = 1'b0;

        if (accept) begin
            stride_d    = cfg_stride;
            mask_d      = cfg_lane_mask;
            next_addr_d = cfg_base_addr;
            beats_d     = cfg_num_iter;
            done_d      = (cfg_num_iter == '0);
        end

        if (issue) begin
            addr_d         = src_addr;
            next_addr_d    = src_addr + src_stride;
            beats_d        = src_beats - CNT_WIDTH'(1);
            req_mask_d     = src_mask;
            req_tag_d.vld  = 1'b1;
            req_tag_d.last = (src_beats == CNT_WIDTH'(1));
        end

        if ((state_q == DRAIN) && fifo_pop && head_last) begin
            done_d = 1'b1;
        end
    end

    // Burst configuration, issue counters and registered memory request
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stride_q    <= '0;
            mask_q      <= '0;
            next_addr_q <= '0;
            beats_q     <= '0;
            addr_q      <= '0;
            req_mask_q  <= '0;
            req_tag_q   <= '0;
            done_q      <= 1'b0;
        end else begin
            stride_q    <= stride_d;
            mask_q      <= mask_d;
            next_addr_q <= next_addr_d;
            beats_q     <= beats_d;
            addr_q      <= addr_d;
            req_mask_q  <= req_mask_d;
            req_tag_q   <= req_tag_d;
            done_q      <= done_d;
        end
    end

    // Read-latency shift register carrying {valid, last} to meet the returning data
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned k = 0; k < READ_LATENCY; k++) pipe_q[k] <= '0;
        end else begin
            pipe_q[0] <= req_tag_q;
            for (int unsigned k = 1; k < READ_LATENCY; k++) pipe_q[k] <= pipe_q[k-1];
        end
    end

    // Zero the lanes that were not requested in this burst
    always_comb begin
        masked_data = '0;
        for (int unsigned g = 0; g < NUM_ELEM; g++) begin
            if (mask_q[g]) begin
                masked_data[g*DATA_WIDTH +: DATA_WIDTH] = mem_read_data[g*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign fifo_push = pipe_q[READ_LATENCY-1].vld;

    vmem_seq_fifo #(
        .WIDTH (ENT_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i ({pipe_q[READ_LATENCY-1].last, masked_data}),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign busy          = (state_q != IDLE);
    assign done          = done_q;
    assign mem_read_req  = req_mask_q;
    assign mem_read_addr = {NUM_ELEM{addr_q}};
    assign out_valid     = !fifo_empty;
    assign out_data      = fifo_head[VEC_W-1:0];
    assign out_last      = head_last;

endmodule
